// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
//   state_t        : loader FSM states
//   WORD_W         : instruction word width in bits
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   TERMINATOR     : end-of-program word; storing it releases the CPU
package instr_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [WORD_W-1:0] TERMINATOR = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte packer: shifts accepted stream bytes into a 32-bit word,
// with the first byte ending up in bits [7:0].
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   clear_i      : restart packing at byte 0 (start of a new load)
//   accept_i     : a byte is transferred this cycle
//   byte_data_i  : the byte being transferred
//   word_o       : packed word; complete in the cycle after word_ready_o
//   word_ready_o : the final byte of a word is accepted this cycle
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_ready_o
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      byte_idx <= '0;
      word_o   <= '0;
    end else if (accept_i) begin
      // Index wraps naturally from BYTES_PER_WORD-1 back to 0.
      byte_idx <= byte_idx + IDX_W'(1);
      // Shift right: after four bytes the first one sits in the LSB lane.
      word_o   <= {byte_data_i, word_o[WORD_W-1:8]};
    end
  end

  assign word_ready_o = accept_i && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader sitting in front of the single-cycle CPU. Packs a byte stream
// into little-endian words, writes them into instruction memory from address
// 0 upward and keeps the CPU in reset until the all-zero terminator word is
// stored, then releases it RST_HOLD cycles later.
//   clk_i / rst_i          : clock, synchronous active-high reset
//   start_i                : one-cycle pulse starting a load (from IDLE or RUN)
//   byte_valid_i/_data_i   : byte stream source
//   byte_ready_o           : loader takes the byte this cycle
//   imem_we_o/_addr_o/_wdata_o : instruction memory write port (byte address)
//   cpu_rst_n_o            : active-low CPU reset
//   done_o                 : program loaded and CPU running
//   word_count_o           : words written in this load, terminator included
//   overflow_err_o         : DEPTH words written without a terminator
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 32,
  parameter int RST_HOLD = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_data_i,
  output logic                     byte_ready_o,
  output logic                     imem_we_o,
  output logic [ADDR_W-1:0]        imem_addr_o,
  output logic [WORD_W-1:0]        imem_wdata_o,
  output logic                     cpu_rst_n_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH):0]   word_count_o,
  output logic                     overflow_err_o
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    word_idx;
  logic [CNT_W-1:0]    word_count;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   write_addr;
  logic [WORD_W-1:0]   packed_word;
  logic                word_ready;
  logic                accept;
  logic                load_start;
  logic                hold_done;

  assign accept     = byte_valid_i && byte_ready_o;
  assign write_addr = ADDR_W'({word_idx, 2'b00});
  assign hold_done  = (hold_cnt == HOLD_W'(RST_HOLD - 1));

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (load_start),
    .accept_i     (accept),
    .byte_data_i  (byte_data_i),
    .word_o       (packed_word),
    .word_ready_o (word_ready)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    unique case (state)
      ST_IDLE, ST_RUN: begin
        if (start_i) begin
          state_nxt  = ST_LOAD;
          load_start = 1'b1;
        end
      end
      ST_LOAD: begin
        if (word_ready) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        // Terminator check comes first so a terminator in the last slot is legal.
        if (packed_word == TERMINATOR)           state_nxt = ST_HOLD;
        else if (word_idx == IDX_W'(DEPTH - 1))  state_nxt = ST_ERROR;
        else                                     state_nxt = ST_LOAD;
      end
      ST_HOLD: begin
        if (hold_done) state_nxt = ST_RUN;
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      word_idx   <= '0;
      word_count <= '0;
      hold_cnt   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (load_start) begin
        word_idx   <= '0;
        word_count <= '0;
      end
      if (state == ST_WRITE) begin
        word_count <= word_count + CNT_W'(1);
        addr_q     <= write_addr;
        wdata_q    <= packed_word;
        hold_cnt   <= '0;
        if (state_nxt == ST_LOAD) word_idx <= word_idx + IDX_W'(1);
      end
      if (state == ST_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Write port shows the live word during WRITE and the last written one after.
  assign imem_we_o      = (state == ST_WRITE);
  assign imem_addr_o    = imem_we_o ? write_addr  : addr_q;
  assign imem_wdata_o   = imem_we_o ? packed_word : wdata_q;
  assign byte_ready_o   = (state == ST_LOAD);
  assign cpu_rst_n_o    = (state == ST_RUN);
  assign done_o         = (state == ST_RUN);
  assign overflow_err_o = (state == ST_ERROR);
  assign word_count_o   = word_count;

endmodule
